// File: rtl/weight_pkg.sv
// weight_pkg: shared widths, per-layer depths and sequencer states for weight BRAM readers
package weight_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int L1_DEPTH = 28;
  localparam int L2_DEPTH = 10;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: 2-entry register FIFO, head always presented on the output
module weight_skid_fifo #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop && count == 2'd2) head <= tail;
      else if (push && (pop || count == 2'd0)) head <= din;
      if (push && (count - 2'(pop)) == 2'd1) tail <= din;
    end
  end
endmodule

// File: rtl/weight_bram_reader.sv
// weight_bram_reader: walks a weight BRAM and streams its words over valid/ready
module weight_bram_reader #(
  parameter int DATA_W = weight_pkg::DATA_W,
  parameter int ADDR_W = weight_pkg::ADDR_W,
  parameter int DEPTH = weight_pkg::L1_DEPTH
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  input  logic [DATA_W-1:0] DO_IN,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_IDX,
  output logic              W_LAST,
  output logic              W_VALID,
  input  logic              W_READY
);
  import weight_pkg::*;
  localparam int W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [1:0] count;
  logic [W-1:0] head;
  logic inflight, issue, last_issue, pop;
  weight_skid_fifo #(.W(W)) u_fifo (
    .clk(CLK),
    .rst_n(RSTN),
    .push(inflight),
    .pop(pop),
    .din({DO_IN, ADDR, ADDR == LAST_A}),
    .count(count),
    .head(head)
  );
  always_comb begin
    pop = W_VALID & W_READY;
    addr_nxt = (state == IDLE) ? '0 : ADDR + 1'b1;
    issue = ((state == FETCH) || (state == IDLE && START)) &&
            (({1'b0, count} + 3'(inflight) - 3'(pop)) < 3'd2);
    last_issue = issue && addr_nxt == LAST_A;
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE && START) ? (last_issue ? DRAIN : FETCH) :
                (state == FETCH && last_issue) ? DRAIN :
                (state == DRAIN && pop && W_LAST) ? IDLE : state;
  end
  always_comb begin
    BUSY = state != IDLE;
    WE = 1'b0;
    W_VALID = count != 2'd0;
    {W_DATA, W_IDX, W_LAST} = head;
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ADDR <= '0;
      EN <= 1'b0;
      inflight <= 1'b0;
      DONE <= 1'b0;
    end else begin
      EN <= issue;
      inflight <= issue;
      DONE <= state == DRAIN && pop && W_LAST;
      if (issue) ADDR <= addr_nxt;
    end
  end
endmodule

// File: tb/tb_weight_bram_reader.sv
// tb_weight_bram_reader: directed checks of the weight BRAM reader at DEPTH=28 and DEPTH=1
module tb_weight_bram_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, start, busy, done, en, we, w_valid, w_ready, w_last;
  logic [4:0] addr, w_idx;
  logic [15:0] do_in = '0, w_data;
  logic start1, busy1, done1, en1, we1, w_valid1, w_ready1, w_last1;
  logic [4:0] addr1, w_idx1;
  logic [15:0] do_in1 = '0, w_data1;
  int n_checks = 0, n_fail = 0;
  weight_bram_reader #(.DATA_W(16), .ADDR_W(5), .DEPTH(28)) u_dut (
    .CLK(clk), .RSTN(rstn), .START(start), .BUSY(busy), .DONE(done),
    .ADDR(addr), .EN(en), .WE(we), .DO_IN(do_in), .W_DATA(w_data),
    .W_IDX(w_idx), .W_LAST(w_last), .W_VALID(w_valid), .W_READY(w_ready)
  );
  weight_bram_reader #(.DATA_W(16), .ADDR_W(5), .DEPTH(1)) u_dut1 (
    .CLK(clk), .RSTN(rstn), .START(start1), .BUSY(busy1), .DONE(done1),
    .ADDR(addr1), .EN(en1), .WE(we1), .DO_IN(do_in1), .W_DATA(w_data1),
    .W_IDX(w_idx1), .W_LAST(w_last1), .W_VALID(w_valid1), .W_READY(w_ready1)
  );
  function automatic logic [15:0] mem_word(input logic [4:0] a);
    return 16'h0100 + 16'(a);
  endfunction
  always @(negedge clk) begin
    if (en) do_in <= mem_word(addr);
    if (en1) do_in1 <= mem_word(addr1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset();
    check("rst_addr", addr, 0);
    check("rst_en", en, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", w_valid, 0);
    check("rst_data", w_data, 0);
    check("rst_idx", w_idx, 0);
    check("rst_last", w_last, 0);
  endtask
  // mode: 0 ready=1, 1 mid-run stall, 2 random ready, 3 start re-pulse, 4 reset after word 10
  task automatic do_run(input int mode);
    int exp_idx, en_cnt, done_cnt, last_cyc, stall, stall_en, post;
    logic stalled;
    exp_idx = 0; en_cnt = 0; done_cnt = 0; last_cyc = -10;
    stall = 0; stall_en = 0; post = 0; stalled = 1'b0;
    w_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_en", en, 1);
    check("start_addr", addr, 0);
    check("start_busy", busy, 1);
    check("start_valid", w_valid, 0);
    for (int cyc = 0; cyc < 400 && post < 3; cyc++) begin
      if (mode == 4 && exp_idx == 11) begin
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_reset();
        for (int k = 0; k < 5; k++) begin
          step();
          check("rst_quiet", {done, w_valid, en, busy}, 0);
        end
        return;
      end
      if (mode == 1 && exp_idx == 8 && !stalled) begin
        stall = 10;
        stalled = 1'b1;
      end
      w_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (stall == 0);
      start = (mode == 3) && (cyc == 5 || cyc == 15);
      if (stall > 0) begin
        check("stall_valid", w_valid, 1);
        check("stall_idx", w_idx, exp_idx);
        check("stall_data", w_data, 16'h0100 + exp_idx);
        stall_en += int'(en);
        stall--;
        if (stall == 0) check("stall_issues_le2", stall_en <= 2, 1);
      end
      check("we", we, 0);
      en_cnt += int'(en);
      if (done_cnt == 0) check("busy", busy, 1);
      if (w_valid && w_ready) begin
        check("idx", w_idx, exp_idx);
        check("data", w_data, 16'h0100 + exp_idx);
        check("last", w_last, exp_idx == 27);
        if (w_last) last_cyc = cyc;
        exp_idx++;
      end
      step();
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_cyc);
        check("done_busy", busy, 0);
      end
      if (done_cnt > 0) post++;
    end
    start = 1'b0;
    w_ready = 1'b1;
    check("n_words", exp_idx, 28);
    check("done_cnt", done_cnt, 1);
    check("en_cycles", en_cnt, 28);
  endtask
  initial begin
    rstn = 1'b0; start = 1'b0; w_ready = 1'b1; start1 = 1'b0; w_ready1 = 1'b1;
    repeat (3) step();
    check_reset();
    check("rst1_valid", w_valid1, 0);
    check("rst1_busy", busy1, 0);
    rstn = 1'b1;
    step();
    do_run(0);
    do_run(1);
    do_run(2);
    do_run(3);
    do_run(4);
    do_run(0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("d1_en", en1, 1);
    check("d1_addr", addr1, 0);
    check("d1_busy", busy1, 1);
    check("d1_valid0", w_valid1, 0);
    step();
    check("d1_valid", w_valid1, 1);
    check("d1_idx", w_idx1, 0);
    check("d1_last", w_last1, 1);
    check("d1_data", w_data1, 16'h0100);
    step();
    check("d1_done", done1, 1);
    check("d1_busy_off", busy1, 0);
    check("d1_valid_off", w_valid1, 0);
    step();
    check("d1_done_pulse", done1, 0);
    check("d1_we", we1, 0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("d1_restart_en", en1, 1);
    check("d1_restart_busy", busy1, 1);
    repeat (3) step();
    check("d1_final_busy", busy1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_bram_reader.md
Name: weight_bram_reader

Overview:
- Read-side sequencer for one per-neuron weight BRAM (16-bit words, 5-bit address, negedge-read, EN/WE protocol).
- On a START pulse, walks addresses 0..DEPTH-1, drives EN/ADDR/WE, captures DO, and streams each weight to the downstream MAC over a valid/ready handshake with full backpressure.
- Sits between the weight BRAM instance and the neuron accumulator; one instance per BRAM.

Parameters:
- DATA_W, 16, weight word width (matches BRAM DO/DI).
- ADDR_W, 5, BRAM address width.
- DEPTH, 28, number of weights read per run; legal range 1..2**ADDR_W.

Ports:
- CLK  in  1  system clock; all block logic on posedge.
- RSTN  in  1  synchronous active-low reset.
- START  in  1  single-cycle run request; sampled only in IDLE.
- BUSY  out  1  high from the edge START is accepted until DONE.
- DONE  out  1  one-cycle pulse after the last weight handshakes.
- ADDR  out  ADDR_W  BRAM address, registered.
- EN  out  1  BRAM enable, registered; high only in read-issue cycles.
- WE  out  1  BRAM write enable; constant 0.
- DO_IN  in  DATA_W  BRAM read data (BRAM updates it on negedge).
- W_DATA  out  DATA_W  weight to MAC.
- W_IDX  out  ADDR_W  address the weight came from.
- W_LAST  out  1  high with the word at index DEPTH-1.
- W_VALID  out  1  W_DATA/W_IDX/W_LAST valid.
- W_READY  in  1  downstream accepts when W_VALID&W_READY at posedge.

Behaviour:
- Reset (RSTN=0 at posedge): state=IDLE; ADDR=0, EN=0, WE=0, BUSY=0, DONE=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0; FIFO emptied; in-flight flag and counters cleared. This applies mid-run: the run is abandoned, no DONE is issued, and any outstanding BRAM read is discarded.
- States:
  - IDLE: START=1 -> FETCH; BUSY=1 from that edge; issue counter=0.
  - FETCH: issues reads. Moves to DRAIN on the edge that issues address DEPTH-1.
  - DRAIN: no issues; waits for the last handshake. On W_VALID&W_READY&W_LAST -> IDLE; DONE=1 for one cycle; BUSY=0 on the same edge.
  - DEPTH=1: FETCH issues address 0, then goes directly to DRAIN.
- START in FETCH/DRAIN is ignored. START on the same edge DONE asserts is ignored; the block is in IDLE only on the following cycle.
- Read timing:
  - An issue at posedge t sets EN=1 and ADDR=a. The BRAM samples them at negedge t+½ and updates DO_IN.
  - The block writes DO_IN into the output FIFO at posedge t+1, tagged idx=a and last=(a==DEPTH-1).
  - EN returns to 0 on any edge with no issue; ADDR holds its last value.
- Issue rule at posedge: state==FETCH and (fifo_count + inflight - pop) < 2, where pop = W_VALID&W_READY. This sustains one weight per cycle with W_READY=1 and never overflows the 2-entry FIFO.
- Output: W_VALID = FIFO non-empty; W_DATA/W_IDX/W_LAST come from the FIFO head. While W_VALID=1 and W_READY=0, all outputs hold stable.
- Simultaneous push and pop at the same edge are both honoured.
- Latency: START edge t0 -> EN=1, ADDR=0 after t0 -> W_VALID=1 after t0+1. Steady state is one word per cycle. DONE follows the edge of the last handshake.
- ADDR never exceeds DEPTH-1. WE is never asserted.

Decomposition:
- Shared package weight_pkg: DATA_W, ADDR_W, and per-layer DEPTH constants; state enum {IDLE, FETCH, DRAIN}.
- One sub-module: weight_skid_fifo, a 2-entry register FIFO with push/pop/count and data+idx+last payload, reset to empty on RSTN=0.

Test Plan:
- BRAM model preloaded with word i = 16'h0100+i, DEPTH=28, W_READY=1, START pulse -> 28 consecutive handshakes with W_DATA 16'h0100..16'h011B, W_IDX 0..27; W_LAST only on idx 27; DONE pulse one cycle later; EN high exactly 28 cycles; WE always 0.
- W_READY held 0 for 10 cycles mid-run -> at most 2 reads issued past the stall; W_VALID, W_DATA and W_IDX stable; no lost or duplicated indices after release.
- Random 50% W_READY -> received sequence is exactly 0..27 in order; FIFO count never exceeds 2; DONE issued once.
- START re-pulsed at cycles 5 and 15 of a run -> ignored; single run of 28 words; BUSY continuous.
- RSTN=0 for one cycle after word 10 -> all outputs at reset values next cycle, no DONE; a new START gives a clean run beginning at idx 0.
- DEPTH=1 build -> one word idx 0 with W_LAST=1; DONE; then back in IDLE.
